// File: rtl/sram_arb_pkg.sv
// Shared types for the group SRAM arbiter: FSM states, requester ids and access kinds.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_SCAN = 1'b0,
        REQ_CORE = 1'b1
    } req_id_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way request picker for the SRAM arbiter. Round-robin by default;
// SRAM_ARB_SCAN_PRIO_EN switches to fixed priority with scan always winning ties.
module rr_pick2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    input  logic       en,
    output logic [1:0] gnt,
    output req_id_t    id
);

`ifdef SRAM_ARB_SCAN_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        id = req[0] ? REQ_SCAN : REQ_CORE;
    end
`else
    // On a tie the requester that did not win last time goes next.
    always_comb begin
        if (req == 2'b11) begin
            id = (last == REQ_SCAN) ? REQ_CORE : REQ_SCAN;
        end else begin
            id = req[1] ? REQ_CORE : REQ_SCAN;
        end
    end
`endif

    always_comb begin
        gnt = 2'b00;
        if (en && (req != 2'b00)) begin
            gnt = (id == REQ_CORE) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sram_share_arb.sv
// Shares the single group SRAM port between the scan controller and the core.
// Build option: SRAM_ARB_SCAN_PRIO_EN gives scan fixed priority instead of round-robin.
//
// state | meaning
// IDLE  | no access in flight; grant the next requester
// BUSY  | strobe held to the SRAM, waiting for sram_ready or timeout
// RESP  | one-cycle ready pulse to the winning requester
module sram_share_arb
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_ren,
    input  logic              s_wen,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_ready,
    input  logic              c_ren,
    input  logic              c_wen,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ready,
    output logic              sram_ren,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready,
    output logic              grant_id,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    req_id_t           last_q;
    req_id_t           grant_q;
    op_t               op_q;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        req;
    logic [1:0]        pick_gnt;
    req_id_t           pick_id;
    logic              win_wen;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [DATA_W-1:0] rsp_data;

    assign req       = {c_ren | c_wen, s_ren | s_wen};
    assign win_wen   = (pick_id == REQ_CORE) ? c_wen   : s_wen;
    assign win_addr  = (pick_id == REQ_CORE) ? c_addr  : s_addr;
    assign win_wdata = (pick_id == REQ_CORE) ? c_wdata : s_wdata;
    // An aborted read returns zero rather than whatever the SRAM bus holds.
    assign rsp_data  = sram_ready ? sram_rdata : '0;
    assign grant_id  = grant_q;

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .en   (state == IDLE),
        .gnt  (pick_gnt),
        .id   (pick_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_q      <= REQ_CORE;
            grant_q     <= REQ_SCAN;
            op_q        <= OP_RD;
            cnt         <= '0;
            sram_ren    <= 1'b0;
            sram_wen    <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            s_rdata     <= '0;
            c_rdata     <= '0;
            s_ready     <= 1'b0;
            c_ready     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            s_ready <= 1'b0;
            c_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_gnt != 2'b00) begin
                        grant_q    <= pick_id;
                        last_q     <= pick_id;
                        op_q       <= win_wen ? OP_WR : OP_RD;
                        sram_addr  <= win_addr;
                        sram_wdata <= win_wdata;
                        sram_ren   <= ~win_wen;
                        sram_wen   <= win_wen;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (sram_ready || (cnt == CNT_LAST)) begin
                        sram_ren <= 1'b0;
                        sram_wen <= 1'b0;
                        if (!sram_ready) begin
                            timeout_err <= 1'b1;
                        end
                        if (op_q == OP_RD) begin
                            if (grant_q == REQ_CORE) begin
                                c_rdata <= rsp_data;
                            end else begin
                                s_rdata <= rsp_data;
                            end
                        end
                        s_ready <= (grant_q == REQ_SCAN);
                        c_ready <= (grant_q == REQ_CORE);
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_share_arb.sv
// Directed bench for sram_share_arb with a small latency-configurable SRAM stub.
// Honours SRAM_ARB_SCAN_PRIO_EN for the expected grant order.
module tb_sram_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_ren, s_wen, c_ren, c_wen;
    logic [10:0] s_addr, c_addr;
    logic [31:0] s_wdata, c_wdata;
    logic [31:0] s_rdata, c_rdata;
    logic        s_ready, c_ready;
    logic        sram_ren, sram_wen;
    logic [10:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;
    logic        grant_id, busy, timeout_err;

    logic [31:0] mem [0:2047];
    int          lat = 0;
    bit          hang = 1'b0;
    int          wait_cnt = 0;

    int n_chk = 0;
    int n_bad = 0;
    int other_hits = 0;
    int dbl_hits = 0;

    always #5 clk = ~clk;

    sram_share_arb #(.ADDR_W(11), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .c_ren(c_ren), .c_wen(c_wen), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    // SRAM stub: completes lat+1 cycles after the strobe appears unless hung.
    always @(negedge clk) begin
        if ((sram_ren || sram_wen) && !hang) begin
            if (wait_cnt >= lat) begin
                sram_ready = 1'b1;
                wait_cnt   = 0;
                if (sram_wen) mem[sram_addr] = sram_wdata;
                else          sram_rdata = mem[sram_addr];
            end else begin
                sram_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            sram_ready = 1'b0;
            wait_cnt   = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit who, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
            if (s_ready && c_ready) dbl_hits++;
            if (who ? s_ready : c_ready) other_hits++;
        end while (!(who ? c_ready : s_ready) && edges < 50);
        chk("wait_ready", who ? c_ready : s_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e;
        int  n_str;
        bit  exp_seq [5];

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[5] = 32'hDEADBEEF;
        rst_n = 1'b0;
        s_ren = 0; s_wen = 0; c_ren = 0; c_wen = 0;
        s_addr = '0; c_addr = '0; s_wdata = '0; c_wdata = '0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ren", sram_ren, 0);
        chk("rst_wen", sram_wen, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_c_ready", c_ready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_s_rdata", s_rdata, 0);
        rst_n = 1'b1;
        tick();

        // 1: scan read with two wait cycles
        lat = 2; other_hits = 0;
        s_ren = 1; s_addr = 11'h005;
        tick();
        chk("t1_busy", busy, 1);
        chk("t1_ren", sram_ren, 1);
        chk("t1_addr", sram_addr, 11'h005);
        chk("t1_grant", grant_id, 0);
        wait_ready(0, e);
        chk("t1_edges", e, 3);
        chk("t1_rdata", s_rdata, 32'hDEADBEEF);
        s_ren = 0;
        tick();
        chk("t1_pulse", s_ready, 0);
        chk("t1_idle", busy, 0);
        chk("t1_c_quiet", other_hits, 0);

        // 2: core write then scan read-back
        lat = 0;
        c_wen = 1; c_addr = 11'h7FF; c_wdata = 32'h12345678;
        tick();
        chk("t2_wen", sram_wen, 1);
        chk("t2_ren", sram_ren, 0);
        chk("t2_addr", sram_addr, 11'h7FF);
        chk("t2_wdata", sram_wdata, 32'h12345678);
        chk("t2_grant", grant_id, 1);
        wait_ready(1, e);
        chk("t2_edges", e, 1);
        chk("t2_c_rdata", c_rdata, 0);
        c_wen = 0;
        tick();
        s_ren = 1; s_addr = 11'h7FF;
        tick();
        chk("t2_rd_grant", grant_id, 0);
        wait_ready(0, e);
        chk("t2_rdata", s_rdata, 32'h12345678);
        s_ren = 0;
        tick();

        // 3: both requesting continuously from reset
        rst_n = 0;
        tick();
        rst_n = 1;
`ifdef SRAM_ARB_SCAN_PRIO_EN
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        s_addr = 11'h7FF; c_addr = 11'h7FF;
        s_ren = 1; c_ren = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_grant", grant_id, exp_seq[i]);
            chk("t3_ren", sram_ren, 1);
            tick();
            chk("t3_s_ready", s_ready, exp_seq[i] == 1'b0);
            chk("t3_c_ready", c_ready, exp_seq[i] == 1'b1);
            if (exp_seq[i]) c_ren = 0; else s_ren = 0;
            tick();
            chk("t3_idle", busy, 0);
            chk("t3_no_ready", s_ready | c_ready, 0);
            if (i < 4) begin
                if (exp_seq[i]) c_ren = 1; else s_ren = 1;
            end
            tick();
        end
        chk("t3_core_last", grant_id, 1);
        tick();
        chk("t3_core_ready", c_ready, 1);
        c_ren = 0;
        tick();

        // 4: SRAM never answers, timeout after four BUSY cycles
        hang = 1;
        s_ren = 1; s_addr = 11'h003;
        tick();
        n_str = 0; e = 0;
        while (sram_ren && e < 20) begin
            n_str++;
            tick();
            e++;
        end
        chk("t4_strobe_cyc", n_str, 4);
        chk("t4_s_ready", s_ready, 1);
        chk("t4_rdata", s_rdata, 0);
        chk("t4_tmo", timeout_err, 1);
        s_ren = 0; hang = 0;
        tick();
        chk("t4_pulse", s_ready, 0);
        c_ren = 1;
        tick();
        wait_ready(1, e);
        c_ren = 0;
        chk("t4_tmo_sticky", timeout_err, 1);
        tick();

        // 5: reset in the middle of an access
        hang = 1;
        c_ren = 1;
        tick();
        chk("t5_busy", busy, 1);
        tick();
        rst_n = 0; c_ren = 0;
        tick();
        chk("t5_ren", sram_ren, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_c_ready", c_ready, 0);
        chk("t5_tmo_clr", timeout_err, 0);
        rst_n = 1; hang = 0;
        tick();
        chk("t5_no_pulse", c_ready, 0);
        s_ren = 1; c_ren = 1;
        tick();
        chk("t5_scan_first", grant_id, 0);
        wait_ready(0, e);
        s_ren = 0;
        wait_ready(1, e);
        c_ren = 0;
        tick();

        // 6: ren and wen together means write
        s_ren = 1; s_wen = 1; s_addr = 11'h010; s_wdata = 32'hA5A55A5A;
        tick();
        chk("t6_wen", sram_wen, 1);
        chk("t6_ren", sram_ren, 0);
        chk("t6_wdata", sram_wdata, 32'hA5A55A5A);
        wait_ready(0, e);
        s_ren = 0; s_wen = 0;
        tick();
        c_ren = 1; c_addr = 11'h010;
        tick();
        wait_ready(1, e);
        chk("t6_readback", c_rdata, 32'hA5A55A5A);
        c_ren = 0;
        tick();

        chk("no_double_ready", dbl_hits, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
